// File: rtl/serial_sub_4bit_if.sv
// serial_sub_4bit_if -- request/result bundle for the serial 4-bit subtractor.
//   start, a, b, borrow_in : request side (driven by master)
//   ready, diff, borrow_out, done : result side (driven by slave)
//   overflow : only when SERIAL_SUB_OVF_EN is defined
interface serial_sub_4bit_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       borrow_in;
  logic       ready;
  logic [3:0] diff;
  logic       borrow_out;
  logic       done;
`ifdef SERIAL_SUB_OVF_EN
  logic       overflow;

  modport master (output start, a, b, borrow_in,
                  input  ready, diff, borrow_out, done, overflow);
  modport slave  (input  start, a, b, borrow_in,
                  output ready, diff, borrow_out, done, overflow);
`else
  modport master (output start, a, b, borrow_in,
                  input  ready, diff, borrow_out, done);
  modport slave  (input  start, a, b, borrow_in,
                  output ready, diff, borrow_out, done);
`endif
endinterface

// File: rtl/serial_sub_4bit.sv
// serial_sub_4bit -- bit-serial 4-bit subtractor, one full-subtractor stage
// reused over four cycles, LSB first.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : serial_sub_4bit_if.slave (start/a/b/borrow_in in,
//          ready/diff/borrow_out/done[/overflow] out)
// Optional: define SERIAL_SUB_OVF_EN to add the signed overflow output.
// Flow: IDLE (accept) -> SHIFT x4 -> DONE (1-cycle pulse) -> IDLE.
module serial_sub_4bit (
  input  logic           clk,
  input  logic           rst,
  serial_sub_4bit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d, b_q, b_d;     // operand shift registers, shift right
  logic       br_q, br_d;             // running borrow
  logic [3:0] res_q, res_d;           // result, filled from the MSB side
  logic [3:0] diff_q, diff_d;
  logic       bo_q, bo_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf_q, ovf_d;
`endif

  // Full subtractor on the current LSBs.
  logic d_bit, br_nxt;
  assign d_bit  = a_q[0] ^ b_q[0] ^ br_q;
  assign br_nxt = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.borrow_in;
          cnt_d   = 2'd0;
          res_d   = 4'h0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d   = {1'b0, a_q[3:1]};
        b_d   = {1'b0, b_q[3:1]};
        br_d  = br_nxt;
        res_d = {d_bit, res_q[3:1]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          diff_d  = {d_bit, res_q[3:1]};
          bo_d    = br_nxt;
`ifdef SERIAL_SUB_OVF_EN
          // On the last bit a_q[0]/b_q[0] hold the captured sign bits.
          ovf_d   = (a_q[0] != b_q[0]) & (d_bit != a_q[0]);
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Handshake flags registered from the next state so outputs stay flops.
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      br_q    <= 1'b0;
      res_q   <= 4'h0;
      diff_q  <= 4'h0;
      bo_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.ready      = ready_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bo_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.overflow   = ovf_q;
`endif

endmodule
